// File: rtl/dual_edge_stimulus_gen.sv
// Edge-stream generator: accepts (num_edges, gap) over valid/ready and toggles
// line x that many times, one toggle every gap+1 cycles, first toggle one cycle after accept.
module dual_edge_stimulus_gen #(
  parameter int   CNT_W      = 8,
  parameter int   GAP_W      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] num_edges,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             x,
  output logic             edge_strobe,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_cnt_next;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_next;
  logic [GAP_W-1:0] gap_reg;
  logic [GAP_W-1:0] gap_reg_next;
  logic             x_next;
  logic             strobe_next;
  logic             done_next;

  logic             accept;
  logic             tick;
  logic             last;

  assign accept = start_valid && start_ready;
  // Abort suppresses any toggle scheduled on the same edge, including the last one.
  assign tick   = (state == RUN) && !abort && (gap_cnt == '0);
  assign last   = tick && (edge_cnt == CNT_W'(1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: each combinational output is assigned a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept && (num_edges != '0)) state_next = RUN;
      RUN:  if (abort || last)               state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    start_ready = (state == IDLE);
    busy        = (state == RUN);
  end

  // Datapath next values: command latch, gap down-counter, edge down-counter.
  always_comb begin
    edge_cnt_next = edge_cnt;
    gap_cnt_next  = gap_cnt;
    gap_reg_next  = gap_reg;
    x_next        = x;
    strobe_next   = 1'b0;
    done_next     = 1'b0;

    if (accept) begin
      edge_cnt_next = num_edges;
      gap_reg_next  = gap;
      gap_cnt_next  = '0;
      done_next     = (num_edges == '0);
    end else if (state == RUN) begin
      if (abort) begin
        edge_cnt_next = '0;
        gap_cnt_next  = '0;
      end else if (tick) begin
        x_next        = ~x;
        strobe_next   = 1'b1;
        if (edge_cnt != '0) edge_cnt_next = edge_cnt - CNT_W'(1);
        gap_cnt_next  = last ? '0 : gap_reg;
        done_next     = last;
      end else begin
        gap_cnt_next  = gap_cnt - GAP_W'(1);
      end
    end
  end

  // Datapath registers; x is never re-initialised between commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt    <= '0;
      gap_cnt     <= '0;
      gap_reg     <= '0;
      x           <= IDLE_LEVEL;
      edge_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      edge_cnt    <= edge_cnt_next;
      gap_cnt     <= gap_cnt_next;
      gap_reg     <= gap_reg_next;
      x           <= x_next;
      edge_strobe <= strobe_next;
      done        <= done_next;
    end
  end

endmodule

// File: tb/tb_dual_edge_stimulus_gen.sv
// Randomized and directed bench for dual_edge_stimulus_gen against a
// schedule-based reference model (toggle i due at accept + 1 + i*(G+1)).
module tb_dual_edge_stimulus_gen;

  localparam logic IDLE_LEVEL = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] num_edges;
  logic [7:0] gap;
  logic       abort;
  logic       x;
  logic       edge_strobe;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  longint cyc = 0;
  bit     m_active;
  longint m_k;
  int     m_n;
  int     m_g;
  int     m_idx;
  logic   m_x;
  logic   m_strobe;
  logic   m_done;

  dual_edge_stimulus_gen #(
    .CNT_W      (8),
    .GAP_W      (8),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .num_edges   (num_edges),
    .gap         (gap),
    .abort       (abort),
    .x           (x),
    .edge_strobe (edge_strobe),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_x      = IDLE_LEVEL;
    m_strobe = 1'b0;
    m_done   = 1'b0;
    m_idx    = 0;
  endtask

  // Predicts the effect of the upcoming rising edge from the current inputs.
  task automatic model_edge();
    m_strobe = 1'b0;
    m_done   = 1'b0;
    if (!m_active) begin
      if (start_valid) begin
        if (num_edges == 0) begin
          m_done = 1'b1;
        end else begin
          m_active = 1'b1;
          m_k      = cyc;
          m_n      = int'(num_edges);
          m_g      = int'(gap);
          m_idx    = 0;
        end
      end
    end else if (abort) begin
      m_active = 1'b0;
    end else if (cyc == m_k + 1 + longint'(m_idx) * longint'(m_g + 1)) begin
      m_x      = ~m_x;
      m_strobe = 1'b1;
      m_idx++;
      if (m_idx == m_n) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("x",           32'(x),           32'(m_x));
    check("edge_strobe", 32'(edge_strobe), 32'(m_strobe));
    check("busy",        32'(busy),        32'(m_active));
    check("done",        32'(done),        32'(m_done));
    check("start_ready", 32'(start_ready), 32'(!m_active));
  endtask

  task automatic step(input logic sv, input logic [7:0] n, input logic [7:0] g, input logic ab);
    start_valid = sv;
    num_edges   = n;
    gap         = g;
    abort       = ab;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    num_edges   = '0;
    gap         = '0;
    abort       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Three toggles back to back, then a spaced even count.
    step(1'b1, 8'd3, 8'd0, 1'b0);
    idle(5);
    step(1'b1, 8'd4, 8'd2, 1'b0);
    idle(12);

    // Zero-length command: done only.
    step(1'b1, 8'd0, 8'd5, 1'b0);
    idle(3);

    // Back-to-back with start_valid held into the done cycle.
    step(1'b1, 8'd2, 8'd1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 8'd0, 1'b0);
    idle(4);

    // Abort coincident with the fifth scheduled toggle.
    step(1'b1, 8'd10, 8'd3, 1'b0);
    idle(16);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    idle(3);

    // Abort while idle must not disturb an accept.
    step(1'b1, 8'd1, 8'd0, 1'b1);
    idle(3);

    // Asynchronous reset between edges mid-command.
    step(1'b1, 8'd10, 8'd2, 1'b0);
    idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'd1, 8'd0, 1'b0);
    idle(3);

    // Field extremes.
    step(1'b1, 8'd3, 8'd255, 1'b0);
    idle(3 * 256 + 2);
    step(1'b1, 8'd255, 8'd0, 1'b0);
    idle(258);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic       sv;
      logic [7:0] n;
      logic [7:0] g;
      logic       ab;
      sv = ($urandom_range(0, 3) == 0);
      g  = ($urandom_range(0, 29) == 0) ? 8'd255 : 8'($urandom_range(0, 4));
      if ($urandom_range(0, 39) == 0) begin
        n = 8'd255;
        g = 8'd0;
      end else begin
        n = 8'($urandom_range(0, 8));
      end
      ab = ($urandom_range(0, 49) == 0);
      step(sv, n, g, ab);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_edge_stimulus_gen.md
Name: dual_edge_stimulus_gen

Overview:
Edge-stream generator: the transmit side of the dual-edge detection path.
- Takes a command (edge count, inter-edge gap) over a valid/ready handshake.
- Drives a single-bit line `x` with exactly that many toggles at a fixed cycle spacing.
- Pairs directly with the dual-edge detector: each toggle on `x` must produce one detector output pulse.
- Used as synthesizable stimulus and as a self-test source for edge-detector instances.

Parameters:
- CNT_W, 8, width of the edge-count field.
- GAP_W, 8, width of the gap field (idle cycles between toggles).
- IDLE_LEVEL, 1'b0, level driven on `x` out of reset.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  command valid.
- start_ready  out  1  command accepted when high together with start_valid; equals (state==IDLE).
- num_edges  in  CNT_W  number of toggles to emit; sampled on accept.
- gap  in  GAP_W  extra cycles between toggles; sampled on accept.
- abort  in  1  synchronous cancel of the running command.
- x  out  1  generated line, registered.
- edge_strobe  out  1  high for the cycle after `x` changed (registered, aligned with the new `x` value).
- busy  out  1  high while state==RUN.
- done  out  1  one-cycle pulse at normal completion.

Behaviour:
Reset:
- While rst_n=0: state=IDLE, x=IDLE_LEVEL, edge_strobe=0, busy=0, done=0, counters=0, start_ready=1.
- The asynchronous assert clears everything immediately, including mid-command; no done is produced.

States:
- IDLE -> RUN on accept with num_edges != 0.
- IDLE -> IDLE on accept with num_edges == 0: done=1 in the following cycle; no toggle.
- RUN -> IDLE at the last toggle, or on abort.

Accept and latching:
- Accept is the rising edge k where start_valid && start_ready are both high.
- num_edges and gap are latched at edge k.
- Input changes after accept have no effect on the running command.

Edge timing (N = num_edges, G = gap):
- Toggle i (i = 0..N-1) happens at edge k+1+i*(G+1).
- The first toggle is 1 cycle after accept.
- G=0 gives a toggle every cycle.
- edge_strobe=1 in exactly the cycles following each toggle edge, so there are N strobes.

Completion:
- At the last toggle edge: state -> IDLE and done -> 1 for one cycle, concurrent with the final edge_strobe.
- busy=1 from edge k through the cycle before the last toggle edge's output cycle; busy=0 in the done cycle.
- start_ready=1 in the done cycle, so back-to-back commands are allowed.
- On back-to-back, the next command's first toggle follows its accept by 1 cycle.

Line level:
- `x` is never reset between commands; it holds its final level.
- Odd N inverts the idle level; even N restores it.

Abort:
- Sampled in RUN only; ignored in IDLE.
- At the sampling edge: no toggle occurs on that edge even if one was scheduled, state -> IDLE, `x` holds its level, done is not asserted, edge_strobe=0 in the next cycle.
- abort and a scheduled last toggle on the same edge: abort wins, and no toggle and no done are produced.

Counters:
- Edge counter: CNT_W bits, counts down, never wraps; reaching 0 is terminal.
- Gap counter: GAP_W bits, reloads G after each toggle.
- G at max (2^GAP_W-1) gives a spacing of 2^GAP_W cycles with no overflow.
- N at max (2^CNT_W-1) is legal.

Test Plan:
1. Reset, then N=3, G=0 accepted at edge k -> x toggles at k+1, k+2, k+3 (0->1->0->1); edge_strobe high 3 consecutive cycles; done with the third strobe; x stays 1.
2. N=4, G=2 -> toggles at k+1, k+4, k+7, k+10; x ends at its start level; done once; busy low from the done cycle; a paired dual_edge detector emits exactly 4 pulses.
3. N=0 -> done=1 in the cycle after accept; x and edge_strobe never change; busy stays 0.
4. Back-to-back: N=2, G=1, then with start_valid held a second N=1, G=0 -> second accept in the done cycle, its toggle 1 cycle later; 3 strobes total, no lost or duplicate edges.
5. N=10, G=3, abort pulsed after the 4th toggle, coincident with the 5th scheduled edge -> exactly 4 toggles, no done, state IDLE, start_ready=1 next cycle.
6. rst_n dropped asynchronously mid-RUN (between clock edges) -> x=IDLE_LEVEL and busy/done/edge_strobe=0 immediately; after release, a new N=1 command produces a single toggle.
